mem_access_master: RTL and testbench



---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_access_master_if.sv | 35 +++
 rtl/mem_lane_extract.sv | 34 +++
 rtl/mem_access_master.sv | 124 ++++++++++++
 tb/tb_mem_access_master.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-bus initiator and its lane logic.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10,
        RESP  = 2'b11
    } state_t;

    // Little-endian lane enables; an illegal size enables no lanes.
    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] addrLo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addrLo;
            SIZE_HALF: be = 4'b0011 << {addrLo[1], 1'b0};
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // True when the access must be refused without a bus cycle.
    function automatic logic accessFault(input logic [1:0] size, input logic [1:0] addrLo);
        logic fault;
        case (size)
            SIZE_BYTE: fault = 1'b0;
            SIZE_HALF: fault = addrLo[0];
            SIZE_WORD: fault = |addrLo;
            default:   fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// Request/response and bus-side signals of the memory-bus initiator.
// Latency: none (wiring only).
// Backpressure: iReq is held or re-issued by the requester until oReady.
interface mem_access_master_if;

    logic        iReq;
    logic        oReady;
    logic        iWrite;
    logic [1:0]  iSize;
    logic        iUnsigned;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic        oDone;
    logic        oError;
    logic [31:0] oRData;
    logic        oReadEnable;
    logic        oWriteEnable;
    logic [3:0]  oByteEnable;
    logic [31:0] oAddress;
    logic [31:0] oWriteData;
    logic [31:0] iReadData;

    modport master (
        input  iReq, iWrite, iSize, iUnsigned, iAddr, iWData, iReadData,
        output oReady, oDone, oError, oRData, oReadEnable, oWriteEnable,
               oByteEnable, oAddress, oWriteData
    );

    modport slave (
        output iReq, iWrite, iSize, iUnsigned, iAddr, iWData, iReadData,
        input  oReady, oDone, oError, oRData, oReadEnable, oWriteEnable,
               oByteEnable, oAddress, oWriteData
    );

endinterface

// File: rtl/mem_lane_extract.sv
// Selects the addressed byte/halfword lane of a read word and extends it.
// Latency: combinational.
// Backpressure: none.
module mem_lane_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [31:0] result
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Lane pick followed by sign or zero extension; words pass through untouched.
    always_comb begin
        byteLane = word[7:0];
        halfLane = addrLo[1] ? word[31:16] : word[15:0];
        case (addrLo)
            2'd0:    byteLane = word[7:0];
            2'd1:    byteLane = word[15:8];
            2'd2:    byteLane = word[23:16];
            default: byteLane = word[31:24];
        endcase
        case (size)
            SIZE_BYTE: result = {{24{~isUnsigned & byteLane[7]}}, byteLane};
            SIZE_HALF: result = {{16{~isUnsigned & halfLane[15]}}, halfLane};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_master.sv
// Turns load/store requests into bus strobes, lane enables and extended read data.
// Latency: store done at T+2, load at T+READ_LATENCY+1, refused request at T+1.
// Backpressure: oReady only in IDLE; iReq while busy is ignored, not queued.
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 2
)
(
    input  logic                 iCLK,
    input  logic                 iRST_n,
    mem_access_master_if.master  bus
);

    localparam int               CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              reqFault;
    logic              writeQ;
    logic              unsignedQ;
    logic              errorQ;
    logic [1:0]        sizeQ;
    logic [31:0]       addrQ;
    logic [31:0]       wdataQ;
    logic [31:0]       rdataQ;
    logic [31:0]       extracted;
    logic              readLast;

    assign accept   = bus.iReq && (state == IDLE);
    assign reqFault = accessFault(bus.iSize, bus.iAddr[1:0]);
    assign readLast = (state == READ) && (cnt == '0);

    mem_lane_extract u_extract (
        .word       (bus.iReadData),
        .addrLo     (addrQ[1:0]),
        .size       (sizeQ),
        .isUnsigned (unsignedQ),
        .result     (extracted)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= stateNext;
    end

    // Request capture, read-latency countdown and the load result register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            writeQ    <= 1'b0;
            unsignedQ <= 1'b0;
            errorQ    <= 1'b0;
            sizeQ     <= SIZE_BYTE;
            addrQ     <= '0;
            wdataQ    <= '0;
            rdataQ    <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                writeQ    <= bus.iWrite;
                unsignedQ <= bus.iUnsigned;
                errorQ    <= reqFault;
                sizeQ     <= bus.iSize;
                addrQ     <= bus.iAddr;
                wdataQ    <= bus.iWData;
                cnt       <= CNT_LAST;
            end else if (state == READ && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (readLast) rdataQ <= extracted;
        end
    end

    // Next state plus all bus/handshake outputs decoded from the current state.
    always_comb begin
        stateNext        = state;
        bus.oReady       = 1'b0;
        bus.oDone        = 1'b0;
        bus.oError       = 1'b0;
        bus.oReadEnable  = 1'b0;
        bus.oWriteEnable = 1'b0;
        bus.oByteEnable  = 4'b0000;
        bus.oAddress     = '0;
        bus.oWriteData   = '0;
        bus.oRData       = rdataQ;
        if (state != IDLE) begin
            bus.oByteEnable = byteEnable(sizeQ, addrQ[1:0]);
            bus.oAddress    = addrQ;
            case (sizeQ)
                SIZE_BYTE: bus.oWriteData = {4{wdataQ[7:0]}};
                SIZE_HALF: bus.oWriteData = {2{wdataQ[15:0]}};
                default:   bus.oWriteData = wdataQ;
            endcase
        end
        case (state)
            IDLE: begin
                bus.oReady = 1'b1;
                if (accept) begin
                    if (reqFault)         stateNext = RESP;
                    else if (bus.iWrite)  stateNext = WRITE;
                    else                  stateNext = READ;
                end
            end
            WRITE: begin
                bus.oWriteEnable = 1'b1;
                stateNext        = RESP;
            end
            READ: begin
                bus.oReadEnable = 1'b1;
                if (cnt == '0) stateNext = RESP;
            end
            default: begin
                bus.oDone  = 1'b1;
                bus.oError = errorQ;
                stateNext  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Drives three initiators (read latency 1, 2, 4) with identical requests and
// compares every cycle against a transaction-timeline model of the bus.
// Stimulus is table-driven for the named cases and $urandom for the rest.
module tb_mem_access_master;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req, wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdat, rdIn;

    always #5 clk = ~clk;

    mem_access_master_if b0 ();
    mem_access_master_if b1 ();
    mem_access_master_if b2 ();

    mem_access_master #(.READ_LATENCY(1)) u0 (.iCLK(clk), .iRST_n(rstN), .bus(b0));
    mem_access_master #(.READ_LATENCY(2)) u1 (.iCLK(clk), .iRST_n(rstN), .bus(b1));
    mem_access_master #(.READ_LATENCY(4)) u2 (.iCLK(clk), .iRST_n(rstN), .bus(b2));

    assign b0.iReq = req; assign b0.iWrite = wr; assign b0.iSize = sz; assign b0.iUnsigned = uns;
    assign b0.iAddr = addr; assign b0.iWData = wdat; assign b0.iReadData = rdIn;
    assign b1.iReq = req; assign b1.iWrite = wr; assign b1.iSize = sz; assign b1.iUnsigned = uns;
    assign b1.iAddr = addr; assign b1.iWData = wdat; assign b1.iReadData = rdIn;
    assign b2.iReq = req; assign b2.iWrite = wr; assign b2.iSize = sz; assign b2.iUnsigned = uns;
    assign b2.iAddr = addr; assign b2.iWData = wdat; assign b2.iReadData = rdIn;

    // {oReady, oDone, oError, oReadEnable, oWriteEnable}
    logic [4:0]  ctl [3];
    logic [3:0]  beo [3];
    logic [31:0] adro[3];
    logic [31:0] wdo [3];
    logic [31:0] rdo [3];

    assign ctl[0] = {b0.oReady, b0.oDone, b0.oError, b0.oReadEnable, b0.oWriteEnable};
    assign ctl[1] = {b1.oReady, b1.oDone, b1.oError, b1.oReadEnable, b1.oWriteEnable};
    assign ctl[2] = {b2.oReady, b2.oDone, b2.oError, b2.oReadEnable, b2.oWriteEnable};
    assign beo[0] = b0.oByteEnable; assign beo[1] = b1.oByteEnable; assign beo[2] = b2.oByteEnable;
    assign adro[0] = b0.oAddress;   assign adro[1] = b1.oAddress;   assign adro[2] = b2.oAddress;
    assign wdo[0] = b0.oWriteData;  assign wdo[1] = b1.oWriteData;  assign wdo[2] = b2.oWriteData;
    assign rdo[0] = b0.oRData;      assign rdo[1] = b1.oRData;      assign rdo[2] = b2.oRData;

    int          errors = 0;
    int          checks = 0;
    string       curName;
    int          LAT[3] = '{1, 2, 4};
    logic [31:0] prevRd[3];

    // Scenario description: transactions and the cycle in which each is accepted.
    int          nTx;
    logic        txW  [2];
    logic [1:0]  txSz [2];
    logic        txUns[2];
    logic [31:0] txAddr[2];
    logic [31:0] txWd [2];
    logic [31:0] txRd [2];
    int          txAcc[2];

    function automatic logic isErr(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] expBe(input logic [1:0] s, input logic [31:0] a);
        int lane = int'(a % 4);
        if (s == 2'd0) return 4'(1 << lane);
        if (s == 2'd1) return 4'(3 << (2 * (lane / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] expWd(input logic [1:0] s, input logic [31:0] w);
        if (s == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] expRd(input logic [1:0] s, input logic u,
                                          input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        if (s == 2'd0) begin
            v = (d >> (8 * (a % 4))) & 32'hFF;
            if (!u && v >= 32'd128) v = v - 32'd256;
        end else if (s == 2'd1) begin
            v = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!u && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Busy cycles after acceptance, the final one being the completion pulse.
    function automatic int dur(input int i, input int L);
        if (isErr(txSz[i], txAddr[i])) return 1;
        if (txW[i]) return 2;
        return L + 1;
    endfunction

    // Load result visible in cycle k: latest successful load whose result has landed.
    function automatic logic [31:0] rdAt(input int d, input int k);
        logic [31:0] v = prevRd[d];
        for (int i = 0; i < nTx; i++)
            if (!txW[i] && !isErr(txSz[i], txAddr[i]) && k >= txAcc[i] + LAT[d] + 1)
                v = expRd(txSz[i], txUns[i], txAddr[i], txRd[i]);
        return v;
    endfunction

    task automatic check_cycle(input int k);
        for (int d = 0; d < 3; d++) begin
            int          L = LAT[d];
            int          act = -1;
            int          p;
            int          dd;
            logic        e;
            logic [4:0]  eCtl;
            logic [31:0] eAdr;
            logic [31:0] eRd;
            for (int i = 0; i < nTx; i++)
                if (k > txAcc[i] && k <= txAcc[i] + dur(i, L)) act = i;
            eRd  = rdAt(d, k);
            eAdr = 32'h0;
            e    = 1'b0;
            if (act < 0) begin
                eCtl = 5'b10000;
            end else begin
                p    = k - txAcc[act];
                dd   = dur(act, L);
                e    = isErr(txSz[act], txAddr[act]);
                eAdr = txAddr[act];
                eCtl = {1'b0, p == dd, e && p == dd, !e && !txW[act] && p <= L, !e && txW[act] && p == 1};
            end
            checks++;
            if (ctl[d] !== eCtl) begin
                errors++;
                $display("FAIL %s L=%0d cyc%0d rdy/done/err/re/we got=%b exp=%b", curName, L, k, ctl[d], eCtl);
            end
            checks++;
            if (rdo[d] !== eRd) begin
                errors++;
                $display("FAIL %s L=%0d cyc%0d oRData got=%h exp=%h", curName, L, k, rdo[d], eRd);
            end
            checks++;
            if (adro[d] !== eAdr) begin
                errors++;
                $display("FAIL %s L=%0d cyc%0d oAddress got=%h exp=%h", curName, L, k, adro[d], eAdr);
            end
            if (act < 0 || !e) begin
                logic [3:0]  eBe = (act < 0) ? 4'h0 : expBe(txSz[act], txAddr[act]);
                logic [31:0] eWd = (act < 0) ? 32'h0 : expWd(txSz[act], txWd[act]);
                checks++;
                if (beo[d] !== eBe) begin
                    errors++;
                    $display("FAIL %s L=%0d cyc%0d oByteEnable got=%b exp=%b", curName, L, k, beo[d], eBe);
                end
                checks++;
                if (wdo[d] !== eWd) begin
                    errors++;
                    $display("FAIL %s L=%0d cyc%0d oWriteData got=%h exp=%h", curName, L, k, wdo[d], eWd);
                end
            end
        end
    endtask

    task automatic commit();
        for (int d = 0; d < 3; d++) prevRd[d] = rdAt(d, 1000);
    endtask

    task automatic run_single(input logic w, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
        nTx = 1; txW[0] = w; txSz[0] = s; txUns[0] = u; txAddr[0] = a;
        txWd[0] = wd; txRd[0] = rd; txAcc[0] = 0;
        @(negedge clk);
        req = 1'b1; wr = w; sz = s; uns = u; addr = a; wdat = wd; rdIn = rd;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check_cycle(k);
            // Scramble everything except read data to prove values were captured.
            req = 1'b0; wr = 1'($urandom); sz = 2'($urandom); addr = $urandom; wdat = $urandom;
        end
        commit();
    endtask

    task automatic test_reset();
        curName = "reset";
        rstN = 1'b0; req = 1'b0; wr = 1'b0; sz = 2'd0; uns = 1'b0;
        addr = 32'h0; wdat = 32'h0; rdIn = 32'h0;
        nTx = 0;
        for (int d = 0; d < 3; d++) prevRd[d] = 32'h0;
        repeat (2) @(negedge clk);
        check_cycle(0);
        rstN = 1'b1;
        @(negedge clk);
        check_cycle(1);
    endtask

    task automatic test_word_store();
        curName = "sw";
        run_single(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h1234_5678);
    endtask

    task automatic test_byte_store();
        curName = "sb";
        run_single(1'b1, 2'd0, 1'b0, 32'h1001_0003, 32'h0000_00A5, 32'h0);
        curName = "sh";
        run_single(1'b1, 2'd1, 1'b0, 32'h1001_0002, 32'hFFFF_C3D2, 32'h0);
    endtask

    task automatic test_loads();
        logic [1:0]  s  [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic        u  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  lo [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        logic [31:0] lit[6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF,
                                32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            curName = $sformatf("load%0d", i);
            run_single(1'b0, s[i], u[i], {30'h0400_4000, lo[i]}, $urandom, 32'h80FF_7F01);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rdo[d] !== lit[i]) begin
                    errors++;
                    $display("FAIL %s L=%0d literal oRData got=%h exp=%h", curName, LAT[d], rdo[d], lit[i]);
                end
            end
        end
    endtask

    task automatic test_errors();
        curName = "lw_misaligned";
        run_single(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0, 32'h5555_AAAA);
        curName = "sh_misaligned";
        run_single(1'b1, 2'd1, 1'b0, 32'h1001_0001, 32'h1357_9BDF, 32'h0);
        curName = "size_illegal";
        run_single(1'b0, 2'd3, 1'b1, 32'h1001_0000, 32'h0, 32'hCAFE_F00D);
    endtask

    task automatic test_back_to_back();
        curName = "b2b";
        nTx = 2;
        txW[0] = 1'b1; txSz[0] = 2'd2; txUns[0] = 1'b0; txAddr[0] = 32'h2000_0010;
        txWd[0] = 32'hA1B2_C3D4; txRd[0] = 32'h0; txAcc[0] = 0;
        txW[1] = 1'b0; txSz[1] = 2'd1; txUns[1] = 1'b0; txAddr[1] = 32'h2000_0022;
        txWd[1] = 32'h0BAD_F00D; txRd[1] = 32'h9F3C_0000; txAcc[1] = 3;
        rdIn = 32'h9F3C_0000;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; sz = 2'd2; uns = 1'b0; addr = txAddr[0]; wdat = txWd[0];
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check_cycle(k);
            if (k == 1) begin
                // A request while busy must be ignored.
                wr = 1'b0; sz = 2'd0; addr = 32'h3333_3331; wdat = 32'h0;
            end else if (k == 2) begin
                wr = 1'b0; sz = 2'd1; uns = 1'b0; addr = txAddr[1]; wdat = txWd[1];
            end else if (k == 4) begin
                req = 1'b0;
            end
        end
        commit();
    endtask

    task automatic test_reset_mid_read();
        curName = "reset_mid_read";
        nTx = 1; txW[0] = 1'b0; txSz[0] = 2'd2; txUns[0] = 1'b0; txAddr[0] = 32'h4000_0008;
        txWd[0] = 32'h0; txRd[0] = 32'h7777_1111; txAcc[0] = 0;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; sz = 2'd2; addr = txAddr[0]; wdat = 32'h0; rdIn = txRd[0];
        @(negedge clk);
        check_cycle(1);
        req = 1'b0;
        #2 rstN = 1'b0;
        #1;
        nTx = 0;
        for (int d = 0; d < 3; d++) prevRd[d] = 32'h0;
        check_cycle(0);
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_cycle(k);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  s = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            curName = $sformatf("rand%0d", n);
            run_single(1'($urandom), s, 1'($urandom), a, $urandom, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
